// File: rtl/mux_sel_arbiter_pkg.sv
// Shared constants for the mux-tree select arbiter: FSM encodings and hold-counter width.
package mux_sel_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_OWN    = 2'd2;

  localparam int unsigned HOLD_W = 8;

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Round-robin winner search: rotate requests down by the pointer, find the lowest set bit,
// then add the pointer back (modulo N_REQ by SEL_W-bit wrap).
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [SEL_W-1:0] win_o,
  output logic             any_o
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   ffs;
  logic               found;

  assign dbl = {req_i, req_i};
  assign rot = dbl[ptr_i +: N_REQ];

  always_comb begin
    ffs   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (rot[i] && !found) begin
        ffs   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

  assign win_o = ffs + ptr_i;
  assign any_o = |req_i;

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner of a shared 2:1 mux tree: SEL settles one cycle before a one-hot GNT,
// with a hold limit that forces release and pulses TMO.
module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_REQ-1:0] REQ,
  output logic [SEL_W-1:0] SEL,
  output logic [N_REQ-1:0] GNT,
  output logic             BUSY,
  output logic             TMO
);

  logic [1:0]        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              tmo_q, tmo_d;
  logic [SEL_W-1:0]  win;
  logic              any_req;

  rr_pick #(.N_REQ(N_REQ), .SEL_W(SEL_W)) u_pick (
    .req_i (REQ),
    .ptr_i (ptr_q),
    .win_o (win),
    .any_o (any_req)
  );

  // sel_q doubles as the current winner index; it is frozen from SETTLE through OWN.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    tmo_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          sel_d   = win;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (REQ[sel_q]) begin
          gnt_d        = '0;
          gnt_d[sel_q] = 1'b1;
          hold_d       = HOLD_W'(1);
          state_d      = ST_OWN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN: begin
        // A drop coinciding with the hold limit is an ordinary release, so TMO needs REQ high.
        if (!REQ[sel_q] || hold_q == HOLD_W'(MAX_HOLD)) begin
          gnt_d   = '0;
          hold_d  = '0;
          ptr_d   = sel_q + SEL_W'(1);
          tmo_d   = REQ[sel_q];
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      hold_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
      tmo_q   <= tmo_d;
    end
  end

  assign SEL  = sel_q;
  assign GNT  = gnt_q;
  assign TMO  = tmo_q;
  assign BUSY = (state_q == ST_SETTLE) || (state_q == ST_OWN);

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter (N_REQ=4, MAX_HOLD=4) against a tenure-level model.
module tb_mux_sel_arbiter;

  localparam int MAXH = 4;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] REQ   = '0;
  logic [1:0] SEL;
  logic [3:0] GNT;
  logic       BUSY;
  logic       TMO;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: who owns the mux, who is a candidate awaiting confirmation, rotation pointer, tenure length.
  int   m_owner, m_cand, m_ptr, m_ten, m_sel;
  logic m_tmo;

  always #5 CLK = ~CLK;

  mux_sel_arbiter #(.N_REQ(4), .SEL_W(2), .MAX_HOLD(MAXH)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .REQ   (REQ),
    .SEL   (SEL),
    .GNT   (GNT),
    .BUSY  (BUSY),
    .TMO   (TMO)
  );

  function automatic logic [3:0] exp_gnt();
    return (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
  endfunction

  function automatic logic exp_busy();
    return (m_owner >= 0) || (m_cand >= 0);
  endfunction

  task automatic model_reset();
    m_owner = -1; m_cand = -1; m_ptr = 0; m_ten = 0; m_sel = 0; m_tmo = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r);
    bit found;
    m_tmo = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_ptr = (m_owner + 1) % 4; m_owner = -1;
      end else if (m_ten == MAXH) begin
        m_tmo = 1'b1; m_ptr = (m_owner + 1) % 4; m_owner = -1;
      end else begin
        m_ten++;
      end
    end else if (m_cand >= 0) begin
      if (r[m_cand]) begin m_owner = m_cand; m_ten = 1; end
      m_cand = -1;
    end else if (r != 4'd0) begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && r[(m_ptr + k) % 4]) begin
          m_cand = (m_ptr + k) % 4; m_sel = m_cand; found = 1;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0; REQ = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic step(input logic [3:0] r);
    @(negedge CLK);
    REQ = r;
    @(posedge CLK);
    model_step(r);
    #1;
  endtask

  task automatic test_reset();
    @(negedge CLK); RST_N = 1'b0; REQ = '0; model_reset();
    #1;
    n_checks++; if (GNT !== 4'd0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", GNT); end
    n_checks++; if (SEL !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", SEL); end
    n_checks++; if (BUSY !== 1'b0 || TMO !== 1'b0) begin n_fail++; $display("FAIL reset_busy_tmo: got %b%b want 00", BUSY, TMO); end
    @(negedge CLK); RST_N = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    step(4'b0100);
    n_checks++; if (SEL !== 2'd2 || GNT !== 4'd0 || BUSY !== 1'b1) begin n_fail++; $display("FAIL single_settle: got sel=%0d gnt=%b busy=%b want sel=2 gnt=0000 busy=1", SEL, GNT, BUSY); end
    step(4'b0100);
    n_checks++; if (GNT !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b want 0100", GNT); end
    repeat (2) step(4'b0100);
    step(4'b0000);
    n_checks++; if (GNT !== 4'd0 || TMO !== 1'b0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL single_release: got gnt=%b tmo=%b busy=%b want 0000 0 0", GNT, TMO, BUSY); end
    step(4'b1111);
    n_checks++; if (SEL !== 2'd3) begin n_fail++; $display("FAIL single_ptr_next: got %0d want 3", SEL); end
  endtask

  task automatic test_rotation();
    int q[$];
    int n_tmo;
    logic [3:0] prev_gnt;
    logic [1:0] prev_sel;
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    prev_gnt = '0; prev_sel = SEL; n_tmo = 0;
    for (int c = 0; c < 40; c++) begin
      step(4'b1111);
      n_checks++; if (GNT !== exp_gnt() || SEL !== 2'(m_sel) || TMO !== m_tmo) begin n_fail++; $display("FAIL rot_cycle%0d: got gnt=%b sel=%0d tmo=%b want gnt=%b sel=%0d tmo=%b", c, GNT, SEL, TMO, exp_gnt(), m_sel, m_tmo); end
      n_checks++; if ($countones(GNT) > 1 || (prev_gnt != 0 && GNT != 0 && SEL !== prev_sel)) begin n_fail++; $display("FAIL rot_invariant: got gnt=%b sel=%0d prev_sel=%0d", GNT, SEL, prev_sel); end
      if (GNT != 0 && GNT != prev_gnt) for (int k = 0; k < 4; k++) if (GNT[k]) q.push_back(k);
      if (TMO) n_tmo++;
      prev_gnt = GNT; prev_sel = SEL;
    end
    n_checks++; if (q.size() < 5) begin n_fail++; $display("FAIL rot_count: got %0d grants want >=5", q.size()); end
    for (int k = 0; k < 5 && k < q.size(); k++) begin
      n_checks++; if (q[k] !== order[k]) begin n_fail++; $display("FAIL rot_order%0d: got %0d want %0d", k, q[k], order[k]); end
    end
    n_checks++; if (n_tmo < 5) begin n_fail++; $display("FAIL rot_tmo_count: got %0d want >=5", n_tmo); end
  endtask

  task automatic test_wrap();
    do_reset();
    step(4'b0100); step(4'b0100); step(4'b0000);
    step(4'b0011);
    n_checks++; if (SEL !== 2'd0) begin n_fail++; $display("FAIL wrap_sel0: got %0d want 0", SEL); end
    step(4'b0011);
    n_checks++; if (GNT !== 4'b0001) begin n_fail++; $display("FAIL wrap_gnt0: got %b want 0001", GNT); end
    step(4'b0010);
    step(4'b0010);
    n_checks++; if (SEL !== 2'd1) begin n_fail++; $display("FAIL wrap_sel1: got %0d want 1", SEL); end
    step(4'b0010);
    n_checks++; if (GNT !== 4'b0010) begin n_fail++; $display("FAIL wrap_gnt1: got %b want 0010", GNT); end
  endtask

  task automatic test_pulse();
    do_reset();
    step(4'b0010);
    n_checks++; if (SEL !== 2'd1 || BUSY !== 1'b1) begin n_fail++; $display("FAIL pulse_settle: got sel=%0d busy=%b want 1 1", SEL, BUSY); end
    step(4'b0000);
    n_checks++; if (GNT !== 4'd0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL pulse_abort: got gnt=%b busy=%b want 0000 0", GNT, BUSY); end
    step(4'b1111);
    n_checks++; if (SEL !== 2'd0) begin n_fail++; $display("FAIL pulse_ptr: got %0d want 0", SEL); end
  endtask

  task automatic test_midreset();
    do_reset();
    step(4'b0010); step(4'b0010); step(4'b0010);
    n_checks++; if (GNT !== 4'b0010) begin n_fail++; $display("FAIL mrst_pre: got %b want 0010", GNT); end
    #2 RST_N = 1'b0;
    #1;
    n_checks++; if (GNT !== 4'd0 || SEL !== 2'd0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL mrst_async: got gnt=%b sel=%0d busy=%b want 0000 0 0", GNT, SEL, BUSY); end
    REQ = '0; model_reset();
    @(negedge CLK); RST_N = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(4'b0000);
      n_checks++; if (TMO !== 1'b0 || BUSY !== 1'b0 || GNT !== 4'd0) begin n_fail++; $display("FAIL mrst_after%0d: got tmo=%b busy=%b gnt=%b want 0 0 0000", c, TMO, BUSY, GNT); end
    end
  endtask

  task automatic test_drop_at_limit();
    do_reset();
    step(4'b0001); step(4'b0001);
    repeat (MAXH - 1) step(4'b0001);
    n_checks++; if (GNT !== 4'b0001) begin n_fail++; $display("FAIL lim_held: got %b want 0001", GNT); end
    step(4'b0000);
    n_checks++; if (TMO !== 1'b0 || GNT !== 4'd0) begin n_fail++; $display("FAIL lim_release: got tmo=%b gnt=%b want 0 0000", TMO, GNT); end
    step(4'b1111);
    n_checks++; if (SEL !== 2'd1) begin n_fail++; $display("FAIL lim_next: got %0d want 1", SEL); end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic [3:0] prev_gnt;
    logic [1:0] prev_sel;
    int wait_c[4];
    do_reset();
    r = '0; prev_gnt = '0; prev_sel = SEL;
    for (int k = 0; k < 4; k++) wait_c[k] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 5) == 0) r[k] = ~r[k];
      step(r);
      n_checks++; if (GNT !== exp_gnt() || SEL !== 2'(m_sel) || TMO !== m_tmo || BUSY !== exp_busy()) begin n_fail++; $display("FAIL rand_cycle%0d: got gnt=%b sel=%0d tmo=%b busy=%b want gnt=%b sel=%0d tmo=%b busy=%b", c, GNT, SEL, TMO, BUSY, exp_gnt(), m_sel, m_tmo, exp_busy()); end
      n_checks++; if ($countones(GNT) > 1 || (prev_gnt != 0 && GNT != 0 && SEL !== prev_sel)) begin n_fail++; $display("FAIL rand_invariant%0d: got gnt=%b sel=%0d prev_sel=%0d", c, GNT, SEL, prev_sel); end
      for (int k = 0; k < 4; k++) begin
        wait_c[k] = (r[k] && !GNT[k]) ? wait_c[k] + 1 : 0;
        if (wait_c[k] > 3 * (MAXH + 2) + 2) begin
          n_checks++; n_fail++; $display("FAIL rand_starve: requester %0d waited %0d want <=%0d", k, wait_c[k], 3 * (MAXH + 2) + 2);
          wait_c[k] = 0;
        end
      end
      prev_gnt = GNT; prev_sel = SEL;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_pulse();
    test_midreset();
    test_drop_at_limit();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
